// File: rtl/turn_sequencer.sv
// -----------------------------------------------------------------------------
// turn_sequencer
//
// Purpose:
//   Game-turn sequencer. On a frame tick taken while idle and enabled it runs
//   NUM_PHASES sub-engines in fixed order. For each phase it issues a start
//   pulse, optionally waits for that phase's done bit, and latches an ack.
//   After the last phase it issues one commit pulse and goes back to idle.
//
// Optional feature:
//   TURN_SEQ_TIMEOUT_EN - when defined, a watchdog bounds every WAIT to
//   TIMEOUT_CYCLES cycles. A timeout sets the sticky timeout_err flag and
//   skips the ack for the timed-out phase. When undefined, WAIT holds
//   indefinitely and timeout_err is tied to 0.
//
// Phase handshake:
//   phase_start[i] is a one-cycle pulse. If WAIT_MASK[i] is set, the
//   sequencer then sits in WAIT with phase_active[i] high. It leaves on the
//   first WAIT cycle in which phase_done[i] is high; a level that is already
//   high counts. phase_done is never sampled in START, and done bits of other
//   phases are ignored. A phase with WAIT_MASK[i]=0 gets its start pulse only.
//
// Ports:
//   clk          in   system clock, posedge
//   reset        in   synchronous active-high reset
//   frame_tick   in   frame sync strobe; starts a turn when idle
//   enable       in   gates turn start; sampled only in IDLE
//   phase_done   in   [NUM_PHASES] per-phase done from the engines
//   phase_start  out  [NUM_PHASES] one-hot one-cycle start pulse
//   phase_active out  [NUM_PHASES] one-hot level while waiting on a phase
//   phase_ack    out  [NUM_PHASES] per-phase ack, held until next turn begins
//   commit       out  one-cycle end-of-turn pulse
//   busy         out  high in every state except IDLE
//   cur_phase    out  [PHASE_W] index of the current phase
//   turn_count   out  [TURN_W] completed-turn count, wraps modulo 2^TURN_W
//   timeout_err  out  sticky watchdog flag
// -----------------------------------------------------------------------------
module turn_sequencer #(
   parameter int                    NUM_PHASES     = 4,
   parameter logic [NUM_PHASES-1:0] WAIT_MASK      = 4'b1101,
   parameter int                    TURN_W         = 8,
   parameter int                    TIMEOUT_CYCLES = 1024,
   localparam int                   PHASE_W        = $clog2(NUM_PHASES)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_tick,
   input  logic                  enable,
   input  logic [NUM_PHASES-1:0] phase_done,
   output logic [NUM_PHASES-1:0] phase_start,
   output logic [NUM_PHASES-1:0] phase_active,
   output logic [NUM_PHASES-1:0] phase_ack,
   output logic                  commit,
   output logic                  busy,
   output logic [PHASE_W-1:0]    cur_phase,
   output logic [TURN_W-1:0]     turn_count,
   output logic                  timeout_err
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      WAIT   = 3'd2,
      NEXT   = 3'd3,
      COMMIT = 3'd4
   } state_t;

   localparam logic [NUM_PHASES-1:0] PHASE_ONE = NUM_PHASES'(1);

   state_t                  state;
   state_t                  nextState;
   logic [PHASE_W-1:0]      curPhase;
   logic [NUM_PHASES-1:0]   ackReg;
   logic [TURN_W-1:0]       turnReg;
   logic [NUM_PHASES-1:0]   phaseSel;
   logic                    lastPhase;
   logic                    doneSeen;
   logic                    timedOut;
   logic                    ackAllowed;
   logic                    errFlag;

   assign lastPhase = (curPhase == PHASE_W'(NUM_PHASES - 1));
   assign doneSeen  = phase_done[curPhase];
   assign phaseSel  = PHASE_ONE << curPhase;

`ifdef TURN_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wdCount;
   logic            skipAck;

   // wdCount holds the number of WAIT cycles already spent. The cycle in which
   // it equals TIMEOUT_CYCLES-1 is the TIMEOUT_CYCLES-th WAIT cycle. A done in
   // that same cycle wins over the timeout.
   assign timedOut   = (state == WAIT) && !doneSeen &&
                       (wdCount == WD_W'(TIMEOUT_CYCLES - 1));
   assign ackAllowed = !skipAck;

   always_ff @(posedge clk) begin
      if (reset) begin
         wdCount <= '0;
         skipAck <= 1'b0;
         errFlag <= 1'b0;
      end else begin
         case (state)
            START: begin
               wdCount <= '0;
               skipAck <= 1'b0;
            end
            WAIT: begin
               wdCount <= wdCount + 1'b1;
               if (timedOut) begin
                  errFlag <= 1'b1;
                  skipAck <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
`else
   assign timedOut   = 1'b0;
   assign ackAllowed = 1'b1;
   assign errFlag    = 1'b0;
`endif

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE:    if (frame_tick && enable) nextState = START;
         START:   nextState = WAIT_MASK[curPhase] ? WAIT : NEXT;
         WAIT:    if (doneSeen || timedOut) nextState = NEXT;
         NEXT:    nextState = lastPhase ? COMMIT : START;
         COMMIT:  nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         curPhase <= '0;
         ackReg   <= '0;
         turnReg  <= '0;
      end else begin
         state <= nextState;
         case (state)
            IDLE: begin
               // Acks from the previous turn stay visible until a new turn starts.
               if (frame_tick && enable) begin
                  curPhase <= '0;
                  ackReg   <= '0;
               end
            end
            NEXT: begin
               if (ackAllowed) ackReg[curPhase] <= 1'b1;
               if (!lastPhase) curPhase <= curPhase + 1'b1;
            end
            COMMIT: begin
               turnReg  <= turnReg + 1'b1;
               curPhase <= '0;
            end
            default: ;
         endcase
      end
   end

   // All outputs are decoded from registered state only.
   assign phase_start  = (state == START) ? phaseSel : '0;
   assign phase_active = (state == WAIT)  ? phaseSel : '0;
   assign phase_ack    = ackReg;
   assign commit       = (state == COMMIT);
   assign busy         = (state != IDLE);
   assign cur_phase    = curPhase;
   assign turn_count   = turnReg;
   assign timeout_err  = errFlag;

endmodule

// File: tb/tb_turn_sequencer.sv
// -----------------------------------------------------------------------------
// tb_turn_sequencer
//
// Self-checking bench for turn_sequencer with the default parameters.
//
// The bench runs three directed sequences:
//   - a full turn with all done bits held high
//   - frame_tick with enable low
//   - a reset asserted while the sequencer waits on phase 2
//
// It then runs a long randomized run. Expected outputs for that run come
// from a turn timeline. Each accepted tick opens a turn. Each phase costs
// START, then its WAIT cycles up to the first done, then NEXT. The turn ends
// with one COMMIT cycle.
// -----------------------------------------------------------------------------
module tb_turn_sequencer;

   localparam int              NP    = 4;
   localparam logic [NP-1:0]   WMASK = 4'b1101;
   localparam int              N     = 8000;
   localparam int              NX    = N + 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          frame_tick;
   logic          enable;
   logic [NP-1:0] phase_done;
   logic [NP-1:0] phase_start;
   logic [NP-1:0] phase_active;
   logic [NP-1:0] phase_ack;
   logic          commit;
   logic          busy;
   logic [1:0]    cur_phase;
   logic [7:0]    turn_count;
   logic          timeout_err;

   int tests = 0;
   int fails = 0;

   // Randomized stimulus and the expected timeline derived from it.
   bit            tickA   [N];
   bit            enA     [N];
   logic [NP-1:0] doneA   [N];
   logic [NP-1:0] eStart  [NX];
   logic [NP-1:0] eAct    [NX];
   logic [NP-1:0] eAckSet [NX];
   logic [NP-1:0] eAck    [NX];
   bit            eCommit [NX];
   bit            eBusy   [NX];
   bit            eAckClr [NX];
   bit            eInc    [NX];
   logic [1:0]    eCur    [NX];
   logic [7:0]    eTurn   [NX];

   always #5 clk = ~clk;

   turn_sequencer #(
      .NUM_PHASES (NP),
      .WAIT_MASK  (WMASK),
      .TURN_W     (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .frame_tick   (frame_tick),
      .enable       (enable),
      .phase_done   (phase_done),
      .phase_start  (phase_start),
      .phase_active (phase_active),
      .phase_ack    (phase_ack),
      .commit       (commit),
      .busy         (busy),
      .cur_phase    (cur_phase),
      .turn_count   (turn_count),
      .timeout_err  (timeout_err)
   );

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag,
                           input logic [NP-1:0] st, input logic [NP-1:0] act,
                           input logic [NP-1:0] ack, input logic cm, input logic bz,
                           input logic [1:0] cur, input logic [7:0] tc, input logic err);
      checkEq({tag, ".start"},  32'(phase_start),  32'(st));
      checkEq({tag, ".active"}, 32'(phase_active), 32'(act));
      checkEq({tag, ".ack"},    32'(phase_ack),    32'(ack));
      checkEq({tag, ".commit"}, 32'(commit),       32'(cm));
      checkEq({tag, ".busy"},   32'(busy),         32'(bz));
      checkEq({tag, ".cur"},    32'(cur_phase),    32'(cur));
      checkEq({tag, ".turn"},   32'(turn_count),   32'(tc));
      checkEq({tag, ".toerr"},  32'(timeout_err),  32'(err));
   endtask

   // Build the expected per-cycle outputs from the random stimulus.
   task automatic buildModel();
      int            freeAt;
      logic [NP-1:0] ack;
      logic [7:0]    tc;
      freeAt = 0;
      for (int k = 0; k < NX; k++) begin
         eStart[k] = '0; eAct[k] = '0; eAckSet[k] = '0; eAck[k] = '0;
         eCommit[k] = 0; eBusy[k] = 0; eAckClr[k] = 0; eInc[k] = 0;
         eCur[k] = '0; eTurn[k] = '0;
      end
      for (int c = 0; c < N; c++) begin
         if (c >= freeAt && tickA[c] && enA[c]) begin
            int p;
            p = c + 1;
            eAckClr[p] = 1;
            for (int i = 0; i < NP; i++) begin
               int w;
               int nxt;
               eStart[p][i] = 1'b1;
               eBusy[p]     = 1;
               eCur[p]      = 2'(i);
               if (WMASK[i]) begin
                  w = p + 1;
                  while (w < N && !doneA[w][i]) begin
                     eAct[w][i] = 1'b1; eBusy[w] = 1; eCur[w] = 2'(i);
                     w++;
                  end
                  eAct[w][i] = 1'b1; eBusy[w] = 1; eCur[w] = 2'(i);
                  nxt = w + 1;
               end else begin
                  nxt = p + 1;
               end
               eBusy[nxt] = 1;
               eCur[nxt]  = 2'(i);
               eAckSet[nxt + 1][i] = 1'b1;
               p = nxt + 1;
            end
            eCommit[p] = 1;
            eBusy[p]   = 1;
            eCur[p]    = 2'(NP - 1);
            eInc[p + 1] = 1;
            freeAt = p + 1;
         end
      end
      ack = '0;
      tc  = '0;
      for (int k = 0; k < NX; k++) begin
         if (eAckClr[k]) ack = '0;
         ack = ack | eAckSet[k];
         if (eInc[k]) tc = tc + 8'd1;
         eAck[k]  = ack;
         eTurn[k] = tc;
      end
   endtask

   initial begin
      int            startAt [NP];
      int            nextAt  [NP];
      logic [NP-1:0] es;
      logic [NP-1:0] ea;
      logic [NP-1:0] ek;
      logic [1:0]    ec;

      startAt = '{1, 4, 6, 9};
      nextAt  = '{3, 5, 8, 11};

      // Reset.
      reset = 1'b1; frame_tick = 1'b0; enable = 1'b0; phase_done = '0;
      stepCycle();
      stepCycle();
      reset = 1'b0;
      checkAll("reset", '0, '0, '0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);

      // Full turn with all done bits held high; tick held through the turn.
      frame_tick = 1'b1; enable = 1'b1; phase_done = 4'b1111;
      for (int c = 1; c <= 13; c++) begin
         stepCycle();
         if (c == 13) frame_tick = 1'b0;
         es = '0; ea = '0; ek = '0; ec = '0;
         for (int i = 0; i < NP; i++) begin
            if (c == startAt[i]) es[i] = 1'b1;
            if (WMASK[i] && c > startAt[i] && c < nextAt[i]) ea[i] = 1'b1;
            if (c > nextAt[i]) ek[i] = 1'b1;
            if (c >= startAt[i] && c <= 12) ec = 2'(i);
         end
         checkAll($sformatf("turn1.c%0d", c), es, ea, ek, (c == 12), (c <= 12), ec,
                  (c >= 13) ? 8'd1 : 8'd0, 1'b0);
      end

      // Tick with enable low: stays idle, acks from the last turn held.
      for (int c = 0; c < 5; c++) begin
         stepCycle();
         frame_tick = 1'b1; enable = 1'b0;
         checkAll($sformatf("noen.c%0d", c), '0, '0, 4'b1111, 1'b0, 1'b0, 2'd0, 8'd1, 1'b0);
      end

      // Phase 2 never reports done: the sequencer waits, then a reset hits mid-wait.
      frame_tick = 1'b1; enable = 1'b1; phase_done = 4'b1011;
      for (int c = 1; c <= 40; c++) begin
         stepCycle();
         frame_tick = 1'b0;
         if (c == 9 || c == 40)
            checkAll($sformatf("wait2.c%0d", c), '0, 4'b0100, 4'b0011, 1'b0, 1'b1, 2'd2, 8'd1, 1'b0);
         if (c == 40) reset = 1'b1;
      end
      stepCycle();
      reset = 1'b0; phase_done = '0;
      checkAll("midreset", '0, '0, '0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
      stepCycle();
      checkAll("postreset", '0, '0, '0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);

      // Randomized run against the timeline model; long enough to wrap turn_count.
      for (int c = 0; c < N; c++) begin
         tickA[c] = ($urandom_range(0, 3) != 0);
         enA[c]   = ($urandom_range(0, 7) != 0);
         for (int i = 0; i < NP; i++) doneA[c][i] = ($urandom_range(0, 2) == 0);
      end
      buildModel();
      reset = 1'b1; frame_tick = 1'b0; enable = 1'b0; phase_done = '0;
      stepCycle();
      reset = 1'b0;
      for (int c = 0; c < N; c++) begin
         if (c > 0) stepCycle();
         frame_tick = tickA[c]; enable = enA[c]; phase_done = doneA[c];
         checkAll($sformatf("rnd.c%0d", c), eStart[c], eAct[c], eAck[c], eCommit[c],
                  eBusy[c], eCur[c], eTurn[c], 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
